// File: rtl/alu_exec_stage.sv
// Single-entry ALU execute stage: computes ADD/SUB/AND/ORR/EOR, evaluates the
// ARM condition code against the APSR flags and holds the result for writeback.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORR = 4'd3,
    ALU_EOR = 4'd4
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;
endpackage

module alu_exec_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  alu_op_t     in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [3:0]  in_rd,
  input  logic        in_set_flags,
  input  logic [3:0]  in_cond,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_rd,
  output logic        out_we,
  output alu_flags_t  flags_q
);

  logic        out_valid_reg;
  logic [31:0] out_result_reg;
  logic [3:0]  out_rd_reg;
  logic        out_we_reg;
  alu_flags_t  flags_reg;

  logic [32:0] sum_next;
  logic [31:0] result_next;
  alu_flags_t  flags_next;
  logic        legal_next;
  logic        cond_ok;
  logic        accept;

  function automatic logic cond_pass(input logic [3:0] cond, input alu_flags_t f);
    logic pass;
    case (cond)
      4'd0:    pass = f.z;
      4'd1:    pass = !f.z;
      4'd2:    pass = f.c;
      4'd3:    pass = !f.c;
      4'd4:    pass = f.n;
      4'd5:    pass = !f.n;
      4'd6:    pass = f.v;
      4'd7:    pass = !f.v;
      4'd8:    pass = f.c && !f.z;
      4'd9:    pass = !f.c || f.z;
      4'd10:   pass = (f.n == f.v);
      4'd11:   pass = (f.n != f.v);
      4'd12:   pass = !f.z && (f.n == f.v);
      4'd13:   pass = f.z || (f.n != f.v);
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

  always_comb begin
    sum_next    = 33'd0;
    result_next = 32'd0;
    flags_next  = flags_reg;
    legal_next  = 1'b1;
    case (in_op)
      ALU_ADD: begin
        sum_next     = {1'b0, in_a} + {1'b0, in_b};
        result_next  = sum_next[31:0];
        flags_next.c = sum_next[32];
        flags_next.v = (in_a[31] == in_b[31]) && (result_next[31] != in_a[31]);
      end
      ALU_SUB: begin
        // Carry out of a + ~b + 1 is the inverted borrow.
        sum_next     = {1'b0, in_a} + {1'b0, ~in_b} + 33'd1;
        result_next  = sum_next[31:0];
        flags_next.c = sum_next[32];
        flags_next.v = (in_a[31] != in_b[31]) && (result_next[31] != in_a[31]);
      end
      ALU_AND: result_next = in_a & in_b;
      ALU_ORR: result_next = in_a | in_b;
      ALU_EOR: result_next = in_a ^ in_b;
      default: legal_next = 1'b0;
    endcase
    if (legal_next) begin
      flags_next.n = result_next[31];
      flags_next.z = (result_next == 32'd0);
    end
  end

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign cond_ok  = cond_pass(in_cond, flags_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_result_reg <= 32'd0;
      out_rd_reg     <= 4'd0;
      out_we_reg     <= 1'b0;
      flags_reg      <= '0;
    end else begin
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg  <= 1'b1;
        out_result_reg <= result_next;
        out_rd_reg     <= in_rd;
        out_we_reg     <= cond_ok && legal_next;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      // Flags commit on the accept edge so the next instruction sees them at once.
      if (accept && in_set_flags && cond_ok && legal_next) begin
        flags_reg <= flags_next;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_rd     = out_rd_reg;
  assign out_we     = out_we_reg;
  assign flags_q    = flags_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed vectors checked with
// immediate assertions, one line printed per transaction.
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  alu_op_t     in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_rd;
  logic        in_set_flags;
  logic [3:0]  in_cond;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_we;
  alu_flags_t  flags_q;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_rd        (in_rd),
    .in_set_flags (in_set_flags),
    .in_cond      (in_cond),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_we       (out_we),
    .flags_q      (flags_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd, input logic s, input logic [3:0] cond);
    in_valid     = 1'b1;
    in_op        = op;
    in_a         = a;
    in_b         = b;
    in_rd        = rd;
    in_set_flags = s;
    in_cond      = cond;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input string name);
    $display("[TB] %-10s valid=%0b we=%0b rd=%0d result=0x%08h flags=%04b in_ready=%0b",
             name, out_valid, out_we, out_rd, out_result, flags_q, in_ready);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = ALU_ADD; in_a = '0; in_b = '0; in_rd = '0;
    in_set_flags = 1'b0; in_cond = 4'd14; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", {28'd0, flags_q}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    show("reset");

    // ADDS 0xFFFFFFFF + 1
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 4'd3, 1'b1, 4'd14);
    step(); show("adds_wrap");
    check("adds_result", out_result, 32'd0);
    check("adds_we", {31'd0, out_we}, 32'd1);
    check("adds_rd", {28'd0, out_rd}, 32'd3);
    check("adds_flags", {28'd0, flags_q}, 32'b0110);

    // SUBS 0x80000000 - 1
    drive(ALU_SUB, 32'h8000_0000, 32'd1, 4'd4, 1'b1, 4'd14);
    step(); show("subs_ovf");
    check("subs_result", out_result, 32'h7FFF_FFFF);
    check("subs_flags", {28'd0, flags_q}, 32'b0011);

    // ADDEQ with Z=0 fails
    drive(ALU_ADD, 32'd1, 32'd2, 4'd5, 1'b1, 4'd0);
    step(); show("addeq");
    check("addeq_valid", {31'd0, out_valid}, 32'd1);
    check("addeq_we", {31'd0, out_we}, 32'd0);
    check("addeq_result", out_result, 32'd3);
    check("addeq_flags", {28'd0, flags_q}, 32'b0011);

    // Back-to-back SUBS 5,5 then ADDNE
    drive(ALU_SUB, 32'd5, 32'd5, 4'd5, 1'b1, 4'd14);
    step(); show("subs_55");
    check("subs55_result", out_result, 32'd0);
    check("subs55_flags", {28'd0, flags_q}, 32'b0110);
    drive(ALU_ADD, 32'd1, 32'd1, 4'd6, 1'b1, 4'd1);
    step(); show("addne");
    check("addne_valid", {31'd0, out_valid}, 32'd1);
    check("addne_we", {31'd0, out_we}, 32'd0);
    check("addne_flags", {28'd0, flags_q}, 32'b0110);

    // Logic ops keep C and V
    drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 4'd1, 1'b1, 4'd14);
    step(); show("adds_v");
    check("addsv_flags", {28'd0, flags_q}, 32'b1001);
    drive(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2, 1'b1, 4'd14);
    step(); show("ands");
    check("ands_result", out_result, 32'hF000_F000);
    check("ands_flags", {28'd0, flags_q}, 32'b1001);
    drive(ALU_ORR, 32'h0000_000F, 32'h0000_00F0, 4'd2, 1'b0, 4'd14);
    step(); show("orr");
    check("orr_result", out_result, 32'h0000_00FF);
    check("orr_flags", {28'd0, flags_q}, 32'b1001);
    drive(ALU_EOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'd2, 1'b1, 4'd14);
    step(); show("eors");
    check("eors_result", out_result, 32'd0);
    check("eors_flags", {28'd0, flags_q}, 32'b0101);

    // Conditions against n0 z1 c0 v1
    drive(ALU_ADD, 32'd1, 32'd1, 4'd1, 1'b0, 4'd10);
    step(); show("cond_ge");
    check("cond_ge_we", {31'd0, out_we}, 32'd0);
    drive(ALU_ADD, 32'd1, 32'd1, 4'd1, 1'b0, 4'd11);
    step(); show("cond_lt");
    check("cond_lt_we", {31'd0, out_we}, 32'd1);
    drive(ALU_ADD, 32'd1, 32'd1, 4'd1, 1'b0, 4'd8);
    step(); show("cond_hi");
    check("cond_hi_we", {31'd0, out_we}, 32'd0);
    drive(ALU_ADD, 32'd1, 32'd1, 4'd1, 1'b0, 4'd9);
    step(); show("cond_ls");
    check("cond_ls_we", {31'd0, out_we}, 32'd1);

    // Backpressure: hold ADDS 10+20, stall SUBS 50-20 for 3 cycles
    drive(ALU_ADD, 32'd10, 32'd20, 4'd7, 1'b1, 4'd14);
    step(); show("adds_30");
    check("adds30_flags", {28'd0, flags_q}, 32'b0000);
    out_ready = 1'b0;
    drive(ALU_SUB, 32'd50, 32'd20, 4'd8, 1'b1, 4'd14);
    for (int i = 0; i < 3; i++) begin
      step(); show("stall");
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_result", out_result, 32'd30);
      check("stall_rd", {28'd0, out_rd}, 32'd7);
      check("stall_flags", {28'd0, flags_q}, 32'b0000);
    end
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    step(); show("subs_30");
    check("subs30_result", out_result, 32'd30);
    check("subs30_rd", {28'd0, out_rd}, 32'd8);
    check("subs30_flags", {28'd0, flags_q}, 32'b0010);

    // Flush with valid held and incoming
    drive(ALU_ADD, 32'd1, 32'd1, 4'd9, 1'b1, 4'd14);
    flush = 1'b1;
    step(); show("flush");
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_flags", {28'd0, flags_q}, 32'b0010);
    flush = 1'b0;
    in_valid = 1'b0;
    step(); show("idle");
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // Illegal opcode 7
    drive(alu_op_t'(4'd7), 32'd5, 32'd5, 4'd9, 1'b1, 4'd14);
    step(); show("illegal");
    check("ill_valid", {31'd0, out_valid}, 32'd1);
    check("ill_result", out_result, 32'd0);
    check("ill_we", {31'd0, out_we}, 32'd0);
    check("ill_flags", {28'd0, flags_q}, 32'b0010);

    // Reset mid-stall
    drive(ALU_ADD, 32'd3, 32'd4, 4'd10, 1'b1, 4'd14);
    out_ready = 1'b0;
    step(); show("prestall");
    check("prestall_in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    show("rst_mid");
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_result", out_result, 32'd0);
    check("rstmid_rd", {28'd0, out_rd}, 32'd0);
    check("rstmid_we", {31'd0, out_we}, 32'd0);
    check("rstmid_flags", {28'd0, flags_q}, 32'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step(); show("post_rst");
    check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("postrst_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
